// File: rtl/morra_pkg.sv
// Shared definitions for the Morra Cinese move collector: move codes,
// PARTITA status codes and collector state encodings.
package morra_pkg;

    // Player move codes; NONE marks an empty slot or a void round.
    typedef enum logic [1:0] {
        MOVE_NONE    = 2'b00,
        MOVE_SASSO   = 2'b01,
        MOVE_CARTA   = 2'b10,
        MOVE_FORBICE = 2'b11
    } move_e;

    // Game status reported back by the game FSM.
    localparam logic [1:0] PARTITA_ONGOING = 2'b00;
    localparam logic [1:0] PARTITA_P1      = 2'b01;
    localparam logic [1:0] PARTITA_P2      = 2'b10;
    localparam logic [1:0] PARTITA_DRAW    = 2'b11;

    // Collector states, kept as plain constants so the encoding stays visible.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_START   = 3'd1;
    localparam state_t ST_COLLECT = 3'd2;
    localparam state_t ST_FIRE    = 3'd3;
    localparam state_t ST_CHECK   = 3'd4;

endpackage

// File: rtl/morra_move_collector_if.sv
// Player-side valid/ready handshake bundle for the move collector.
// The master side belongs to the players, the slave side to the collector.
interface morra_move_collector_if;

    logic       p1_valid;
    logic [1:0] p1_move;
    logic       p1_ready;
    logic       p2_valid;
    logic [1:0] p2_move;
    logic       p2_ready;

    modport master (
        output p1_valid, p1_move, p2_valid, p2_move,
        input  p1_ready, p2_ready
    );

    modport slave (
        input  p1_valid, p1_move, p2_valid, p2_move,
        output p1_ready, p2_ready
    );

endinterface

// File: rtl/morra_move_slot.sv
// One player's move holding slot: a move register plus full flag.
// Ready is decoded from the registered full flag and the collect enable,
// so it never depends combinationally on the player's valid.
module morra_move_slot
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       valid,
    input  logic [1:0] move_in,
    input  logic       clear,
    output logic       ready,
    output logic       accept,
    output logic       full,
    output logic [1:0] move
);

    assign ready  = enable && !full;
    assign accept = valid && ready && (move_in != MOVE_NONE);

    // Latch an accepted move; clearing wins over a same-cycle acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            move <= MOVE_NONE;
        end else if (clear) begin
            full <= 1'b0;
            move <= MOVE_NONE;
        end else if (accept) begin
            full <= 1'b1;
            move <= move_in;
        end
    end

endmodule

// File: rtl/morra_move_collector.sv
// Front-end for the MorraCinese game FSM: collects one move per player,
// fires them together as a single round, sequences the INIZIA start beat
// and stops collecting once PARTITA reports the game is over.
// Optional feature: define MORRA_TIMEOUT_EN to flush a lone move after
// TIMEOUT_CYCLES cycles of waiting for the opponent.
module morra_move_collector
    import morra_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_req,
    input  logic [3:0] cfg_rounds,
    input  logic [1:0] PARTITA,
    output logic       INIZIA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       round_fire,
    output logic       timeout_evt,
    morra_move_collector_if.slave bus
);

    state_t     state;
    state_t     state_next;
    logic       collect;
    logic       clear_slots;
    logic       flush;
    logic       fire_cond;
    logic       ready1;
    logic       ready2;
    logic       acc1;
    logic       acc2;
    logic       full1;
    logic       full2;
    logic [1:0] move1;
    logic [1:0] move2;
    logic [1:0] move1_next;
    logic [1:0] move2_next;

    assign collect     = (state == ST_COLLECT);
    assign clear_slots = start_req || (state == ST_FIRE) || flush;

    morra_move_slot u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (collect),
        .valid   (bus.p1_valid),
        .move_in (bus.p1_move),
        .clear   (clear_slots),
        .ready   (ready1),
        .accept  (acc1),
        .full    (full1),
        .move    (move1)
    );

    morra_move_slot u_slot2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (collect),
        .valid   (bus.p2_valid),
        .move_in (bus.p2_move),
        .clear   (clear_slots),
        .ready   (ready2),
        .accept  (acc2),
        .full    (full2),
        .move    (move2)
    );

    assign bus.p1_ready = ready1;
    assign bus.p2_ready = ready2;

    // Slot contents as they will be after this edge, so FIRE can present
    // a move accepted on the very edge that completes the pair.
    assign move1_next = acc1 ? bus.p1_move : move1;
    assign move2_next = acc2 ? bus.p2_move : move2;
    assign fire_cond  = collect && (full1 || acc1) && (full2 || acc2);

`ifdef MORRA_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;
    logic        one_full;

    assign one_full = full1 ^ full2;
    assign flush    = !start_req && collect && one_full && !acc1 && !acc2
                      && (wait_cnt == WAIT_LIMIT);

    // Count cycles a lone move has waited; any occupancy change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 16'd0;
        end else if (start_req || !collect || !one_full || acc1 || acc2 || flush) begin
            wait_cnt <= 16'd0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    // Without the timeout a lone move waits forever; the parameter only
    // stays to keep the instantiation interface identical in both builds.
    assign flush = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // Next-state decode; a start request overrides everything else.
    always_comb begin
        state_next = state;
        if (start_req) begin
            state_next = ST_START;
        end else begin
            case (state)
                ST_IDLE:    state_next = ST_IDLE;
                ST_START:   state_next = ST_COLLECT;
                ST_COLLECT: state_next = fire_cond ? ST_FIRE : ST_COLLECT;
                ST_FIRE:    state_next = ST_CHECK;
                ST_CHECK:   state_next = (PARTITA != PARTITA_ONGOING) ? ST_IDLE : ST_COLLECT;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered FSM-side outputs, loaded with what the entered state drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            INIZIA      <= 1'b0;
            PRIMO       <= MOVE_NONE;
            SECONDO     <= MOVE_NONE;
            round_fire  <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            INIZIA      <= (state_next == ST_START);
            round_fire  <= (state_next == ST_FIRE);
            timeout_evt <= flush;
            if (state_next == ST_START) begin
                PRIMO   <= cfg_rounds[3:2];
                SECONDO <= cfg_rounds[1:0];
            end else if (state_next == ST_FIRE) begin
                PRIMO   <= move1_next;
                SECONDO <= move2_next;
            end else begin
                PRIMO   <= MOVE_NONE;
                SECONDO <= MOVE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_morra_move_collector.sv
// Directed, table-driven bench for morra_move_collector. Build with
// MORRA_TIMEOUT_EN defined to exercise the lone-move timeout.
module tb_morra_move_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_req;
    logic [3:0] cfg_rounds;
    logic [1:0] PARTITA;
    logic       INIZIA;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       round_fire;
    logic       timeout_evt;

    morra_move_collector_if bus ();

    morra_move_collector #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_req   (start_req),
        .cfg_rounds  (cfg_rounds),
        .PARTITA     (PARTITA),
        .INIZIA      (INIZIA),
        .PRIMO       (PRIMO),
        .SECONDO     (SECONDO),
        .round_fire  (round_fire),
        .timeout_evt (timeout_evt),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected bits: {INIZIA, PRIMO, SECONDO, p1_ready, p2_ready, round_fire, timeout_evt}
    typedef struct {
        string      name;
        logic       start;
        logic [3:0] cfg;
        logic       v1;
        logic [1:0] m1;
        logic       v2;
        logic [1:0] m2;
        logic [1:0] partita;
        logic [8:0] expv;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] e(input logic in, input logic [1:0] pr, input logic [1:0] se,
                                     input logic r1, input logic r2, input logic fire);
        return {in, pr, se, r1, r2, fire, 1'b0};
    endfunction

    function automatic logic [8:0] outVec();
        return {INIZIA, PRIMO, SECONDO, bus.p1_ready, bus.p2_ready, round_fire, timeout_evt};
    endfunction

    task automatic addVec(input string name, input logic start, input logic [3:0] cfg,
                          input logic v1, input logic [1:0] m1, input logic v2, input logic [1:0] m2,
                          input logic [1:0] partita, input logic [8:0] expv);
        vec_t v;
        v.name = name; v.start = start; v.cfg = cfg;
        v.v1 = v1; v.m1 = m1; v.v2 = v2; v.m2 = m2;
        v.partita = partita; v.expv = expv;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        start_req    = v.start;
        cfg_rounds   = v.cfg;
        bus.p1_valid = v.v1;
        bus.p1_move  = v.m1;
        bus.p2_valid = v.v2;
        bus.p2_move  = v.m2;
        PARTITA      = v.partita;
    endtask

    task automatic idleInputs();
        start_req    = 1'b0;
        cfg_rounds   = 4'd0;
        bus.p1_valid = 1'b0;
        bus.p1_move  = 2'b00;
        bus.p2_valid = 1'b0;
        bus.p2_move  = 2'b00;
        PARTITA      = 2'b00;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] expv);
        logic [8:0] got;
        got = outVec();
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %b want %b (INIZIA,PRIMO,SECONDO,p1_ready,p2_ready,round_fire,timeout_evt)",
                     name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: inputs held across one rising edge, outputs expected after it.
        addVec("start_beat",     1, 4'b0010, 0, 2'b00, 0, 2'b00, 2'b00, e(1, 2'b00, 2'b10, 0, 0, 0));
        addVec("collect_entry",  0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 1, 1, 0));
        addVec("p1_carta",       0, 4'b0000, 1, 2'b10, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 1, 0));
        addVec("p1_wait1",       0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 1, 0));
        addVec("p1_wait2",       0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 1, 0));
        addVec("p1_wait3",       0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 1, 0));
        addVec("p1_wait4",       0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 1, 0));
        addVec("p2_sasso_fire",  0, 4'b0000, 0, 2'b00, 1, 2'b01, 2'b00, e(0, 2'b10, 2'b01, 0, 0, 1));
        addVec("check_state",    0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 0, 0));
        addVec("back_collect",   0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 1, 1, 0));
        addVec("same_cycle",     0, 4'b0000, 1, 2'b11, 1, 2'b11, 2'b00, e(0, 2'b11, 2'b11, 0, 0, 1));
        addVec("drop_in_fire",   0, 4'b0000, 1, 2'b01, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 0, 0));
        addVec("drop_in_check",  0, 4'b0000, 1, 2'b01, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 1, 1, 0));
        addVec("none_ignored",   0, 4'b0000, 1, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 1, 1, 0));
        addVec("p1_sasso",       0, 4'b0000, 1, 2'b01, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 1, 0));
        addVec("p2_carta_fire",  0, 4'b0000, 1, 2'b10, 1, 2'b10, 2'b00, e(0, 2'b01, 2'b10, 0, 0, 1));
        addVec("check2",         0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 0, 0));
        addVec("game_over",      0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b01, e(0, 2'b00, 2'b00, 0, 0, 0));
        addVec("idle_refuse",    0, 4'b0000, 1, 2'b01, 1, 2'b01, 2'b01, e(0, 2'b00, 2'b00, 0, 0, 0));
        addVec("idle_hold",      0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b01, e(0, 2'b00, 2'b00, 0, 0, 0));
        addVec("restart",        1, 4'b1111, 0, 2'b00, 0, 2'b00, 2'b00, e(1, 2'b11, 2'b11, 0, 0, 0));
        addVec("collect2",       0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 1, 1, 0));
        addVec("p1_forbice",     0, 4'b0000, 1, 2'b11, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 0, 1, 0));
        addVec("start_clears",   1, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(1, 2'b00, 2'b00, 0, 0, 0));
        addVec("slots_cleared",  0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, e(0, 2'b00, 2'b00, 1, 1, 0));
        addVec("p2_carta",       0, 4'b0000, 0, 2'b00, 1, 2'b10, 2'b00, e(0, 2'b00, 2'b00, 1, 0, 0));

        // Power-on reset.
        rst_n = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 9'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput(vecs[i].name, vecs[i].expv);
        end

        // Asynchronous reset mid-round with player 2's slot full.
        idleInputs();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 9'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", 9'd0);
        bus.p1_valid = 1'b1;
        bus.p1_move  = 2'b01;
        bus.p2_valid = 1'b1;
        bus.p2_move  = 2'b10;
        tick();
        checkOutput("idle_ignores_moves", 9'd0);
        idleInputs();

        // Lone move waiting for an opponent.
        start_req = 1'b1;
        tick();
        checkOutput("to_start", e(1, 2'b00, 2'b00, 0, 0, 0));
        start_req = 1'b0;
        tick();
        checkOutput("to_collect", e(0, 2'b00, 2'b00, 1, 1, 0));
        bus.p1_valid = 1'b1;
        bus.p1_move  = 2'b01;
        tick();
        bus.p1_valid = 1'b0;
        bus.p1_move  = 2'b00;
        checkOutput("to_p1_held", e(0, 2'b00, 2'b00, 0, 1, 0));
`ifdef MORRA_TIMEOUT_EN
        for (int k = 2; k <= 8; k++) begin
            tick();
            checkOutput($sformatf("to_wait%0d", k), e(0, 2'b00, 2'b00, 0, 1, 0));
        end
        tick();
        checkOutput("to_event", 9'b0_00_00_1_1_0_1);
        tick();
        checkOutput("to_after", e(0, 2'b00, 2'b00, 1, 1, 0));
`else
        begin
            int seen;
            seen = 0;
            repeat (1000) begin
                tick();
                if (timeout_evt !== 1'b0) seen++;
            end
            checks++;
            if (seen != 0) begin
                failures++;
                $display("[TB] FAIL no_timeout_pulse: got %0d pulses want 0", seen);
            end
            checkOutput("lone_move_waits", e(0, 2'b00, 2'b00, 0, 1, 0));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morra_move_collector.md
# morra_move_collector

Upstream front-end for the `MorraCinese` game FSM. It accepts asynchronous, independently timed move submissions from two players through valid/ready handshakes and holds each move until both players have committed. It then presents the pair to the FSM as a single one-cycle round on `PRIMO`/`SECONDO`. It also sequences the one-cycle `INIZIA` game-start beat that carries the round-count configuration, and it stops accepting moves once the FSM's `PARTITA` output reports a finished game.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles one committed move waits for the opponent before both slots are flushed (range 1..65535).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_req`  in  1  request a new game; sampled every cycle.
- `cfg_rounds`  in  4  round-count code placed on `{PRIMO,SECONDO}` during the start beat.
- `p1_valid` / `p1_move`  in  1 / 2  player-1 submission.
- `p2_valid` / `p2_move`  in  1 / 2  player-2 submission.
- `p1_ready` / `p2_ready`  out  1  the slot is empty and the block is in COLLECT.
- `PARTITA`  in  2  game status fed back from the FSM (00 = in progress).
- `INIZIA`  out  1  start beat to the FSM.
- `PRIMO` / `SECONDO`  out  2  moves to the FSM; 00 when no round is fired.
- `round_fire`  out  1  one-cycle pulse coincident with a fired round.
- `timeout_evt`  out  1  one-cycle pulse when the slots are flushed by timeout.

## Operation
- Move codes: 00 NONE, 01 SASSO, 10 CARTA, 11 FORBICE. A submission with move 00 is ignored and the slot stays empty.
- States:
  - IDLE: reset state and post-game state. Ready outputs are low.
  - START: a 1-cycle state. Drives `INIZIA`=1 and `{PRIMO,SECONDO}`=`cfg_rounds`.
  - COLLECT: accepts submissions.
  - FIRE: a 1-cycle state. Drives `PRIMO`=slot1 and `SECONDO`=slot2, pulses `round_fire`, and clears both slots.
  - CHECK: a 1-cycle state. Samples `PARTITA`.
- Transitions:
  - `start_req`=1 in any state goes to START next cycle and clears both slots and the timeout counter. This has highest priority.
  - START goes to COLLECT.
  - COLLECT goes to FIRE on the cycle after both slots are full.
  - FIRE goes to CHECK.
  - CHECK goes to IDLE if `PARTITA`≠00, otherwise to COLLECT.
- Handshake: a submission is accepted when `pX_valid` and `pX_ready` are both high. The move is latched on that edge. Ready drops the following cycle and stays low until FIRE or a flush. `pX_valid` while ready is low is dropped, with no queuing.
- Both players submitting in the same cycle: both moves are latched, and FIRE follows on the next cycle.
- Outside START and FIRE, `INIZIA`=0 and `PRIMO`=`SECONDO`=00. The FSM treats 00 as a void round.

## Timing
- Reset values: state IDLE; `INIZIA`=0, `PRIMO`=`SECONDO`=00; ready outputs 0; `round_fire`=0; `timeout_evt`=0; slots NONE; counter 0.
- All outputs are registered. There are no combinational input-to-output paths except ready, which is decoded from registered state.
- Latency:
  - From `start_req` sampled high to `INIZIA` high: 1 cycle.
  - From the second accepted move to `round_fire`: 1 cycle.
  - From FIRE to the earliest next acceptance: 2 cycles (through CHECK).
- Reset asserted mid-round discards latched moves immediately. There is no partial round output.
- Game-over: if `PARTITA`≠00 at CHECK, the block goes to IDLE and moves are refused until the next `start_req`.

## Configuration
- `MORRA_TIMEOUT_EN` defined:
  - A 16-bit counter runs in COLLECT while exactly one slot is full.
  - When the counter reaches `TIMEOUT_CYCLES`, both slots are cleared and `timeout_evt` pulses for 1 cycle. The counter then resets.
  - The counter resets whenever the slot occupancy changes.
- `MORRA_TIMEOUT_EN` undefined: there is no counter, `timeout_evt` is tied 0, and a lone move waits indefinitely.

## Structure
- `morra_pkg`: the move enum (NONE/SASSO/CARTA/FORBICE), the `PARTITA` status codes (00 ongoing, 01 P1, 10 P2, 11 draw), and the collector state enum.
- Sub-module `morra_move_slot`, instantiated twice: one move register plus full flag, with load/clear inputs and ready generation.

## Test plan
- Reset, then `start_req`=1 with `cfg_rounds`=4'b0010 -> `INIZIA`=1 and `PRIMO`/`SECONDO`=00/10 for exactly 1 cycle; ready outputs high 1 cycle later.
- p1 submits 10 at cycle t and p2 submits 01 at t+5 -> `round_fire`, `PRIMO`=10, `SECONDO`=01 at t+6, for 1 cycle only.
- Both players submit in the same cycle (11, 11) -> fire on the next cycle; a repeated `p1_valid` during FIRE/CHECK is dropped.
- `PARTITA`=01 driven during CHECK -> IDLE, ready outputs stay low, and submissions are ignored until `start_req`.
- With `MORRA_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: p1 submits and p2 stays silent -> `timeout_evt` fires 8 cycles later, slots are clear, and both ready outputs are high. Without the macro, nothing fires after 1000 cycles.
- `rst_n` pulled low while one slot is full -> all outputs at reset values asynchronously; after release, state is IDLE.
